// File: rtl/modn_timer_ctrl.sv
// Programmable mod-N timer controller: holds modulus/mode config and sequences
// a wrapping up-counter from start/stop/clear commands.
//
//   state   | meaning
//   --------+----------------------------------------------
//   S_IDLE  | stopped, count 0, config writable
//   S_RUN   | counting, wraps at n_reg-1
//   S_PAUSE | counting suspended, count held
//   S_DONE  | one-shot finished, count 0, config writable
module modn_timer_ctrl #(
  parameter int W         = 4,
  parameter int N_DEFAULT = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_cfg_we,
  input  logic [W-1:0] i_cfg_n,
  input  logic         i_cfg_periodic,
  input  logic         i_start,
  input  logic         i_stop,
  input  logic         i_clr,
  output logic [W-1:0] o_count,
  output logic         o_tc,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TWO = W'(2);

  state_t       r_state;
  logic [W-1:0] r_count;
  logic [W-1:0] r_n;
  logic         r_per;
  logic         r_tc;
  logic         r_busy;
  logic         r_done;
  logic         r_err;

  logic w_cfg_window;
  logic w_cfg_ok;
  logic w_last;
  logic w_go;
  logic w_advance;

  assign w_cfg_window = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_cfg_ok     = i_cfg_we && w_cfg_window && (i_cfg_n >= TWO);
  assign w_last       = (r_count == (r_n - ONE));
  assign w_go         = i_start && !i_stop;
  // A resume from PAUSE counts on the same edge as the start command.
  assign w_advance    = ((r_state == S_RUN) && !i_stop) ||
                        ((r_state == S_PAUSE) && w_go);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_n     <= W'(N_DEFAULT);
      r_per   <= 1'b1;
      r_tc    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= i_cfg_we && !w_cfg_ok;
      r_tc  <= 1'b0;
      if (w_cfg_ok) begin
        r_n   <= i_cfg_n;
        r_per <= i_cfg_periodic;
      end
      if (i_clr) begin
        r_state <= S_IDLE;
        r_count <= '0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else if (w_advance) begin
        if (w_last) begin
          r_count <= '0;
          r_tc    <= 1'b1;
          if (r_per) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end else begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end else begin
          r_count <= r_count + ONE;
          r_state <= S_RUN;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
        end
      end else if (w_go && w_cfg_window) begin
        r_state <= S_RUN;
        r_count <= '0;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
      end else if ((r_state == S_RUN) && i_stop) begin
        r_state <= S_PAUSE;
      end
    end
  end

  assign o_count = r_count;
  assign o_tc    = r_tc;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_err   = r_err;

endmodule

// File: doc/modn_timer_ctrl.md
# modn_timer_ctrl

Controller that sequences a mod-N up-counter as a programmable timer. It holds the modulus and the mode, and runs the counter from start/stop/clear commands. It produces a terminal-count pulse, busy/done status and a configuration-error flag. It sits between a simple command/config source and the downstream logic that consumes `count` and `tc`.

## Interface
- `W`, 4: counter and modulus width.
- `N_DEFAULT`, 10: modulus loaded at reset. Must satisfy 2 ≤ N_DEFAULT ≤ 2^W−1.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  write `cfg_n`/`cfg_periodic` into the config registers.
- `cfg_n`  in  W  requested modulus.
- `cfg_periodic`  in  1  1 = auto-restart after wrap; 0 = one-shot.
- `start`  in  1  begin, resume or restart counting.
- `stop`  in  1  pause counting (count holds).
- `clr`  in  1  abort to IDLE, count cleared.
- `count`  out  W  current count, range 0..n_reg−1.
- `tc`  out  1  one-cycle terminal-count pulse.
- `busy`  out  1  high in RUN or PAUSE.
- `done`  out  1  high in DONE (one-shot finished).
- `err`  out  1  one-cycle pulse on a rejected config write.

## Operation
- Internal registers:
  - `n_reg` resets to N_DEFAULT.
  - `per_reg` resets to 1.
  - State resets to IDLE.
- Reset values of outputs: `count`=0, `tc`=0, `busy`=0, `done`=0, `err`=0.
- FSM states and transitions:
  - IDLE:
    - `start` → RUN with `count`=0.
  - RUN:
    - Count increments by 1 each cycle.
    - At `count`==n_reg−1 the next edge wraps `count` to 0 and sets `tc`.
    - If per_reg=1, stay in RUN. If per_reg=0, go to DONE.
    - `stop` → PAUSE.
  - PAUSE:
    - `count` holds.
    - `start` → RUN and counting continues from the held value.
  - DONE:
    - `count`=0, `done`=1.
    - `start` → RUN with `count`=0.
- Command priority per cycle: `rst` > `clr` > `stop` > `start`.
  - `clr` in any state → IDLE, `count`=0, `done`=0. The config registers are unaffected.
  - `start` and `stop` in the same cycle: `stop` wins. From RUN go to PAUSE; in other states nothing happens.
  - `start` in RUN is ignored. `stop` in IDLE, PAUSE or DONE is ignored.
- Config writes:
  - Accepted only in IDLE or DONE, and only when 2 ≤ `cfg_n`.
  - An accepted write updates n_reg and per_reg on that edge.
  - A write with `cfg_n` < 2, or any `cfg_we` in RUN/PAUSE, is rejected. Both registers stay unchanged and `err` pulses for one cycle.
  - `cfg_we` together with `start` in IDLE or DONE: the new config applies and the run starts in the same edge, so the new modulus governs that run.
- Arithmetic:
  - The wrap compare is `count`==n_reg−1, computed at width W.
  - `count` never reaches or exceeds n_reg.
  - No 2^W overflow is possible because n_reg ≤ 2^W−1.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- `start` sampled at edge k gives `busy`=1 and `count`=0 after edge k. `count`=1 after edge k+1.
- Period in RUN is exactly n_reg cycles from `count`=0 to the next `count`=0.
- `tc` is high for exactly one cycle, coincident with the `count`=0 that follows the wrap. `tc` is never high in IDLE, PAUSE or DONE, except in the single cycle that DONE is entered.
- One-shot:
  - DONE is entered on the wrap edge, so `tc`=1 and `done`=1 in the same cycle.
  - `busy` falls on that same edge.
- `stop` at edge k:
  - `count` after edge k equals its value before edge k; no increment occurs at edge k.
  - `busy` stays 1.
- `stop` on the wrap cycle: the pause wins and no wrap occurs. `count` holds at n_reg−1 and `tc` stays 0.
- `err` appears one cycle after the offending `cfg_we`, is high for one cycle, and is independent of state changes.
- `rst` or `clr` mid-run takes effect on the next edge; any in-flight `tc` is suppressed.

## Test plan
- Reset and defaults:
  - Stimulus: hold `rst`=1 for 2 cycles, then release.
  - Required: `count`=0, `tc`=`busy`=`done`=`err`=0.
  - Then stimulus: pulse `start`.
  - Required: `count` runs 0..9 and `tc` pulses every 10 cycles, indefinitely.
- One-shot N=4:
  - Stimulus: `cfg_we`=1, `cfg_n`=4, `cfg_periodic`=0 in IDLE, then `start`.
  - Required: `count` sequence 0,1,2,3,0. `tc`=`done`=1 on the final 0, `busy`=0 from then on, `count` stays 0.
  - Then stimulus: a second `start`.
  - Required: the same sequence repeats.
- Pause/resume:
  - Stimulus: N=10 periodic; `stop` when `count`=5, hold `stop` 3 cycles, then `start`.
  - Required: `count` stays 5 for the pause, then continues 6,7,8,9,0 with `tc` at the 0.
  - Stimulus: `start` and `stop` together in RUN.
  - Required: the block enters PAUSE.
- Config rejection:
  - Stimulus: `cfg_we` with `cfg_n`=1 in IDLE.
  - Required: `err` pulses once and n_reg stays 10.
  - Stimulus: `cfg_we` with `cfg_n`=6 during RUN.
  - Required: `err` pulses and the period stays 10.
- Clear and reset mid-run:
  - Stimulus: `clr` at `count`=9.
  - Required: next cycle `count`=0, state IDLE, `tc`=0.
  - Stimulus: `rst` at `count`=3.
  - Required: all outputs at reset values and n_reg=N_DEFAULT.
- Stop on wrap:
  - Stimulus: `stop` at `count`=9 with N=10.
  - Required: `count` holds 9 and `tc` stays 0.
  - Then stimulus: `start`.
  - Required: next cycle `count`=0 with `tc`=1.
